// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose : Shared types and constants for the bit-serial adder.
//           - state_t       : sequencer states (IDLE / RUN / DONE)
//           - DEFAULT_WIDTH : default operand width
//           - cnt_width()   : width of the bit counter for a given operand
//                             width, never less than one bit so that a
//                             WIDTH=1 build still has a legal counter vector
// Ports   : none (package)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int cnt_width(input int width);
      if (width <= 1) begin
         return 1;
      end
      return $clog2(width);
   endfunction

endpackage : serial_adder_pkg

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa
//
// Purpose : One-bit full-adder cell, purely combinational.
// Ports   : i_a, i_b   - addend bits
//           i_cin      - carry in
//           o_sum      - sum bit   (i_a ^ i_b ^ i_cin)
//           o_carry    - carry out (majority of the three inputs)
// -----------------------------------------------------------------------------
module fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_carry
);

   logic half_sum;

   assign half_sum = i_a ^ i_b;
   assign o_sum    = half_sum ^ i_cin;
   // Generate when both bits are set, propagate an incoming carry otherwise.
   assign o_carry  = (i_a & i_b) | (i_cin & half_sum);

endmodule : fa

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Purpose : Bit-serial WIDTH-bit adder. Operands and a carry-in are taken
//           through a valid/ready handshake, added LSB-first one bit per clock
//           through a single fa cell (carry kept in a flip-flop), and the
//           WIDTH-bit sum plus carry-out are offered through a second
//           valid/ready handshake.
//
// Parameters
//   WIDTH    operand / sum width, 1..64
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset; aborts any operation in flight
//   i_valid  operands present (only looked at in IDLE)
//   o_ready  block is idle and will take operands on this edge
//   i_a      operand A
//   i_b      operand B
//   i_cin    carry-in
//   o_valid  result available (DONE)
//   i_ready  consumer takes the result
//   o_sum    sum bits; hold the last result in DONE and IDLE
//   o_carry  carry-out; holds with o_sum
//   o_busy   high while bits are being shifted (RUN)
//
// Timing : accept at edge k -> o_valid after edge k+WIDTH. The result
//          handshake edge returns to IDLE, so a new accept can happen no
//          earlier than the edge after that (period WIDTH+2).
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_busy
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t           state_reg;
   state_t           state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] b_next;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] sum_next;
   logic             carry_reg;
   logic             carry_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // ------------------------------------------------------------------
   // Per-cycle control decodes and shifted register images
   // ------------------------------------------------------------------
   logic             accept;
   logic             result_taken;
   logic             last_bit;
   logic             fa_sum;
   logic             fa_carry;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] sum_shift;

   // Decoded from the registered state, so there is no combinational path
   // from i_valid/i_ready to o_ready/o_valid.
   assign accept       = (state_reg == IDLE) && i_valid;
   assign result_taken = (state_reg == DONE) && i_ready;
   assign last_bit     = (cnt_reg == LAST_BIT);

   // ------------------------------------------------------------------
   // The single full-adder cell: always looks at the current LSBs and the
   // running carry. Its outputs are only consumed while in RUN.
   // ------------------------------------------------------------------
   fa u_fa (
      .i_a     (a_reg[0]),
      .i_b     (b_reg[0]),
      .i_cin   (carry_reg),
      .o_sum   (fa_sum),
      .o_carry (fa_carry)
   );

   // ------------------------------------------------------------------
   // Right-shift images. Operands shift in zeros at the MSB; the sum
   // register takes the freshly computed bit at the MSB so that after
   // WIDTH shifts bit 0 of the result has arrived at position 0.
   // The MSB is split out so that WIDTH=1 never indexes past the vector.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == WIDTH - 1) begin : g_msb
            assign a_shift[gi]   = 1'b0;
            assign b_shift[gi]   = 1'b0;
            assign sum_shift[gi] = fa_sum;
         end else begin : g_body
            assign a_shift[gi]   = a_reg[gi+1];
            assign b_shift[gi]   = b_reg[gi+1];
            assign sum_shift[gi] = sum_reg[gi+1];
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Returning to IDLE rather than straight to RUN: a result
            // handshake never doubles as an operand accept.
            if (result_taken) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (pure state decodes)
   // ------------------------------------------------------------------
   always_comb begin
      o_ready = 1'b0;
      o_busy  = 1'b0;
      o_valid = 1'b0;
      case (state_reg)
         IDLE:    o_ready = 1'b1;
         RUN:     o_busy  = 1'b1;
         DONE:    o_valid = 1'b1;
         default: o_ready = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      a_next     = a_reg;
      b_next     = b_reg;
      sum_next   = sum_reg;
      carry_next = carry_reg;
      cnt_next   = cnt_reg;

      if (accept) begin
         a_next     = i_a;
         b_next     = i_b;
         sum_next   = '0;
         carry_next = i_cin;
         cnt_next   = '0;
      end else if (state_reg == RUN) begin
         a_next     = a_shift;
         b_next     = b_shift;
         sum_next   = sum_shift;
         carry_next = fa_carry;
         // Counter stops on the last bit so it never wraps in narrow builds.
         if (!last_bit) begin
            cnt_next = cnt_reg + CNT_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers. In DONE and IDLE nothing above changes them, which
   // is what keeps o_sum/o_carry steady until the next accept.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         a_reg     <= a_next;
         b_reg     <= b_next;
         sum_reg   <= sum_next;
         carry_reg <= carry_next;
         cnt_reg   <= cnt_next;
      end
   end

   // After the final RUN edge the carry flip-flop holds the carry-out of
   // the top bit, so it doubles as the result carry.
   assign o_sum   = sum_reg;
   assign o_carry = carry_reg;

endmodule : serial_adder

// File: doc/serial_adder.md
# serial_adder

Bit-serial multi-bit adder built around the team's `fa` full-adder cell. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It adds them LSB-first at one bit per clock, with the carry held in a flip-flop, and presents the WIDTH-bit sum and carry-out through a second valid/ready handshake. It is the sequential stage directly around `fa`: it feeds `fa` one bit pair per cycle and consumes its `o_sum`/`o_carry`, trading latency for area in the datapath.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 1..64.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  operand request.
- o_ready  output  1  block can accept operands.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in.
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts the result.
- o_sum  output  WIDTH  sum bits.
- o_carry  output  1  carry-out.
- o_busy  output  1  high while in RUN.

## Operation
- FSM states:
  - IDLE: o_ready=1.
  - RUN: shifting; o_busy=1.
  - DONE: o_valid=1.
- IDLE→RUN on `i_valid && o_ready`:
  - load A and B into shift registers;
  - carry register ← i_cin;
  - bit counter ← 0;
  - clear the sum shift register.
- RUN, each cycle:
  - `fa` inputs are A[0], B[0] and the carry register;
  - sum register shifts right with `fa.o_sum` entering at MSB;
  - carry register ← `fa.o_carry`;
  - A and B shift right;
  - counter increments.
- RUN→DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1).
- DONE→IDLE on `o_valid && i_ready`.
- Arithmetic: {o_carry, o_sum} = i_a + i_b + i_cin, exact, WIDTH+1 bits; no overflow is possible.
- i_valid, i_a, i_b and i_cin are ignored outside IDLE; operands are sampled only on the accept edge.
- o_sum and o_carry:
  - hold the last result in DONE;
  - remain stable in IDLE until the next accept;
  - are undefined-but-deterministic during RUN (intermediate register contents).
- No same-cycle turnaround: a result handshake in DONE does not also accept new operands. o_ready rises the cycle after DONE exits.
- Reset asserted at any time, including mid-RUN, aborts the operation:
  - state → IDLE;
  - all registers → 0;
  - the in-flight result is lost.

## Timing
- Reset values: o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0.
- Latency: operands accepted at edge k ⇒ o_valid high after edge k+WIDTH.
- Throughput: one addition per WIDTH+2 cycles with i_ready held high (accept, WIDTH RUN edges, result handshake).
- o_valid and o_ready are registered state decodes, with no combinational path from i_valid or i_ready.
- In DONE with i_ready low, o_valid, o_sum and o_carry hold indefinitely.
- WIDTH=1: a single RUN cycle; latency is 1 edge.
- Reset deassertion takes effect synchronously at the first following edge; no operation is accepted on the deassertion edge itself.

## Structure
- `serial_adder_pkg`:
  - `state_t` enum {IDLE, RUN, DONE};
  - `DEFAULT_WIDTH = 8`;
  - counter width function `$clog2(WIDTH)` guarded to a minimum of 1.
- Sub-module: one instance of the existing `fa` cell for the per-bit sum/carry. All sequencing lives in `serial_adder`.

## Test plan
- Reset, then 0x00+0x00, cin 0 → after 8 RUN edges o_valid=1, o_sum=0x00, o_carry=0; o_busy high exactly 8 cycles.
- 0xFF+0x01, cin 0 → o_sum=0x00, o_carry=1; o_valid first high 8 edges after accept.
- 0xA5+0x5A, cin 1 → o_sum=0x00, o_carry=1. Then 0x37+0x48, cin 0 → o_sum=0x7F, o_carry=0, with i_ready high (back-to-back, 10-cycle period).
- Backpressure: result 0x7F held with i_ready low for 5 cycles while i_valid toggles and i_a changes → outputs stable and o_ready=0 throughout; exactly one result handshake.
- Reset pulsed mid-RUN after 3 bits → all outputs 0 and o_ready=1 immediately; next add 0x10+0x20 → 0x30, carry 0.
- WIDTH=1 build: 1+1, cin 1 → o_sum=1, o_carry=1 one edge after accept. Random sweep of 1000 WIDTH=8 vectors matched against the `+` model.
